rv_csr_arbiter: RTL and testbench

//  Shares the single CSR register file between NUM_THREADS hardware threads.

---
 rtl/rv_csr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rv_csr_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_csr_arbiter.sv
// Shares one CSR file among NUM_THREADS threads: arbitrate, read, modify, write back, respond.
// Define CSR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module rv_csr_arbiter #(
   parameter int NUM_THREADS = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_THREADS-1:0]            thr_req,
   input  logic [2*NUM_THREADS-1:0]          thr_op,
   input  logic [NUM_THREADS*ADDR_WIDTH-1:0] thr_addr,
   input  logic [NUM_THREADS*DATA_WIDTH-1:0] thr_wdata,
   output logic [NUM_THREADS-1:0]            thr_done,
   output logic [DATA_WIDTH-1:0]             thr_rdata,
   output logic                              thr_illegal,
   output logic                              busy,
   output logic                              csr_en,
   output logic [ADDR_WIDTH-1:0]             csr_addr_out,
   input  logic [DATA_WIDTH-1:0]             csr_rdata,
   input  logic                              csr_wr_ok,
   output logic [ADDR_WIDTH-1:0]             csr_addr_in,
   output logic [DATA_WIDTH-1:0]             csr_in,
   output logic                              csr_wr
);
   localparam int IDW = $clog2(NUM_THREADS);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WB, S_RESP} state_t;
   state_t state, state_n;

   logic [1:0]            op_a    [NUM_THREADS];
   logic [ADDR_WIDTH-1:0] addr_a  [NUM_THREADS];
   logic [DATA_WIDTH-1:0] wdata_a [NUM_THREADS];

   for (genvar g = 0; g < NUM_THREADS; g++) begin : g_unpack
      assign op_a[g]    = thr_op[2*g +: 2];
      assign addr_a[g]  = thr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[g] = thr_wdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   function automatic logic write_needed(input logic [1:0] op, input logic [DATA_WIDTH-1:0] w);
      return (op == 2'b01) || (op[1] && (w != '0));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] modify(input logic [1:0] op,
                                                    input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] w);
      case (op)
         2'b10:   return old | w;
         2'b11:   return old & ~w;
         default: return w;
      endcase
   endfunction

   logic           grant_vld;
   logic [IDW-1:0] grant_id;

`ifdef CSR_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (!grant_vld && thr_req[IDW'(i)]) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0] rr_ptr;
   logic [IDW:0]   cand;

   // Search starts at rr_ptr and wraps past NUM_THREADS-1 back to 0.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         cand = {1'b0, rr_ptr} + (IDW+1)'(i);
         if (cand >= (IDW+1)'(NUM_THREADS)) cand = cand - (IDW+1)'(NUM_THREADS);
         if (!grant_vld && thr_req[cand[IDW-1:0]]) begin
            grant_vld = 1'b1;
            grant_id  = cand[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (state == S_IDLE && grant_vld) begin
         rr_ptr <= (grant_id == IDW'(NUM_THREADS-1)) ? '0 : grant_id + 1'b1;
      end
   end
`endif

   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [IDW-1:0]        id_q;
   logic                  wr_need_q;

   always_ff @(posedge clk) begin
      if (state == S_IDLE && grant_vld) begin
         op_q      <= op_a[grant_id];
         addr_q    <= addr_a[grant_id];
         wdata_q   <= wdata_a[grant_id];
         id_q      <= grant_id;
         wr_need_q <= write_needed(op_a[grant_id], wdata_a[grant_id]);
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (grant_vld) state_n = S_RD;
         S_RD:    state_n = S_WB;
         S_WB:    state_n = S_RESP;
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         csr_en       <= 1'b0;
         csr_addr_out <= '0;
         csr_addr_in  <= '0;
         thr_done     <= '0;
         thr_rdata    <= '0;
         thr_illegal  <= 1'b0;
      end else begin
         state       <= state_n;
         busy        <= (state_n != S_IDLE);
         csr_en      <= (state_n == S_RD) || (state_n == S_WB);
         csr_addr_in <= (state_n == S_WB) ? addr_q : '0;
         case (state_n)
            S_RD:    csr_addr_out <= addr_a[grant_id];
            S_WB:    csr_addr_out <= addr_q;
            default: csr_addr_out <= '0;
         endcase
         // Response registers load at the WB->RESP edge and clear one cycle later.
         if (state == S_WB) begin
            thr_done    <= NUM_THREADS'(1) << id_q;
            thr_rdata   <= csr_rdata;
            thr_illegal <= wr_need_q & ~csr_wr_ok;
         end else begin
            thr_done    <= '0;
            thr_rdata   <= '0;
            thr_illegal <= 1'b0;
         end
      end
   end

   // Read data and the protection bit only arrive in WB, so the write strobe is decoded there.
   always_comb begin
      csr_wr = 1'b0;
      csr_in = '0;
      if (state == S_WB && wr_need_q) begin
         csr_in = modify(op_q, csr_rdata, wdata_q);
         csr_wr = csr_wr_ok;
      end
   end

endmodule

// File: tb/tb_rv_csr_arbiter.sv
// Bench for rv_csr_arbiter: directed cases then randomized rounds against a transaction-level model.
module tb_rv_csr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    thr_req;
   logic [2*N-1:0]  thr_op;
   logic [N*AW-1:0] thr_addr;
   logic [N*DW-1:0] thr_wdata;
   logic [N-1:0]    thr_done;
   logic [DW-1:0]   thr_rdata;
   logic            thr_illegal, busy, csr_en, csr_wr, csr_wr_ok;
   logic [AW-1:0]   csr_addr_out, csr_addr_in;
   logic [DW-1:0]   csr_rdata, csr_in;

   logic [1:0]      op_a [N];
   logic [AW-1:0]   addr_a [N];
   logic [DW-1:0]   wd_a [N];

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign thr_op[2*g +: 2]     = op_a[g];
      assign thr_addr[g*AW +: AW] = addr_a[g];
      assign thr_wdata[g*DW +: DW] = wd_a[g];
   end

   rv_csr_arbiter #(.NUM_THREADS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .thr_req(thr_req), .thr_op(thr_op), .thr_addr(thr_addr),
      .thr_wdata(thr_wdata), .thr_done(thr_done), .thr_rdata(thr_rdata),
      .thr_illegal(thr_illegal), .busy(busy), .csr_en(csr_en), .csr_addr_out(csr_addr_out),
      .csr_rdata(csr_rdata), .csr_wr_ok(csr_wr_ok), .csr_addr_in(csr_addr_in),
      .csr_in(csr_in), .csr_wr(csr_wr));

   always #5 clk = ~clk;

   // CSR file model: registered read, write on strobe, plus a backdoor for preloading.
   logic [DW-1:0] mem  [0:(1<<AW)-1];
   logic          prot [0:(1<<AW)-1];
   logic          bd_en = 1'b0;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_val;
   logic          bd_ok;

   always @(posedge clk) begin
      if (csr_en) begin
         csr_rdata <= mem[csr_addr_out];
         csr_wr_ok <= prot[csr_addr_out];
      end
      if (csr_wr) mem[csr_addr_in] <= csr_in;
      if (bd_en) begin
         mem[bd_addr]  <= bd_val;
         prot[bd_addr] <= bd_ok;
      end
   end

   int n_assert = 0;
   int n_fail   = 0;
   int ref_ptr  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_csr(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic ok);
      bd_addr = a; bd_val = v; bd_ok = ok; bd_en = 1'b1;
      @(negedge clk);
      bd_en = 1'b0;
   endtask

   function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
`ifdef CSR_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (req[i]) return i;
`else
      for (int i = 0; i < N; i++) if (req[(ptr + i) % N]) return (ptr + i) % N;
`endif
      return -1;
   endfunction

   function automatic int ref_next_ptr(input int granted, input int ptr);
`ifdef CSR_ARB_FIXED_PRIO_EN
      return ptr;
`else
      return (granted + 1) % N;
`endif
   endfunction

   task automatic wait_access(input int scr, output logic [N-1:0] dvec, output logic [DW-1:0] rd,
                              output logic ill, output int lat, output int nwr,
                              output logic [AW-1:0] wa, output logic [DW-1:0] wd);
      bit done = 0;
      bit scrambled = 0;
      dvec = '0; rd = '0; ill = 1'b0; lat = -1; nwr = 0; wa = '0; wd = '0;
      for (int c = 1; c <= 12 && !done; c++) begin
         @(negedge clk);
         if (scr >= 0 && busy && !scrambled) begin
            op_a[scr] = ~op_a[scr]; addr_a[scr] = ~addr_a[scr]; wd_a[scr] = ~wd_a[scr];
            scrambled = 1;
         end
         if (csr_wr) begin nwr++; wa = csr_addr_in; wd = csr_in; end
         if (thr_done != '0) begin
            dvec = thr_done; rd = thr_rdata; ill = thr_illegal; lat = c; done = 1;
         end
      end
   endtask

   task automatic expect_access(input string tag, input int scr, input int exp_t,
                                input logic [DW-1:0] exp_rd, input logic exp_ill, input int exp_nwr,
                                input logic [AW-1:0] exp_wa, input logic [DW-1:0] exp_wd,
                                input int exp_lat);
      logic [N-1:0] dvec; logic [DW-1:0] rd; logic ill; int lat; int nwr;
      logic [AW-1:0] wa; logic [DW-1:0] wd;
      wait_access(scr, dvec, rd, ill, lat, nwr, wa, wd);
      chk({tag, "_done"},    64'(dvec), 64'(N'(1) << exp_t));
      chk({tag, "_latency"}, 64'(lat),  64'(exp_lat));
      chk({tag, "_rdata"},   64'(rd),   64'(exp_rd));
      chk({tag, "_illegal"}, 64'(ill),  64'(exp_ill));
      chk({tag, "_nwr"},     64'(nwr),  64'(exp_nwr));
      if (exp_nwr > 0) begin
         chk({tag, "_wr_addr"}, 64'(wa), 64'(exp_wa));
         chk({tag, "_wr_data"}, 64'(wd), 64'(exp_wd));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] ref_mem  [8];
   logic          ref_prot [8];
   int            ra [N];

   initial begin
      logic [N-1:0] mask, pending;
      int k, first, scr;
      logic need, ill;
      logic [DW-1:0] old, nw;

      rst = 1'b1; thr_req = '0;
      for (int t = 0; t < N; t++) begin op_a[t] = 2'b00; addr_a[t] = '0; wd_a[t] = '0; end
      @(negedge clk); @(negedge clk);
      chk("reset_done",  64'(thr_done), 64'd0);
      chk("reset_busy",  64'(busy), 64'd0);
      chk("reset_csren", 64'(csr_en), 64'd0);
      chk("reset_wr",    64'(csr_wr), 64'd0);
      chk("reset_rdata", 64'(thr_rdata), 64'd0);
      rst = 1'b0;

      // Single read of 0x340
      set_csr(12'h340, 32'hDEAD_BEEF, 1'b1);
      op_a[1] = 2'b00; addr_a[1] = 12'h340; wd_a[1] = 32'h1234;
      thr_req = 4'b0010;
      expect_access("read", -1, 1, 32'hDEAD_BEEF, 1'b0, 0, '0, '0, 3);
      thr_req = '0; ref_ptr = ref_next_ptr(1, ref_ptr);

      // CSRRS
      set_csr(12'h300, 32'h8, 1'b1);
      op_a[0] = 2'b10; addr_a[0] = 12'h300; wd_a[0] = 32'h80;
      thr_req = 4'b0001;
      expect_access("csrrs", -1, 0, 32'h8, 1'b0, 1, 12'h300, 32'h88, 3);
      thr_req = '0; ref_ptr = ref_next_ptr(0, ref_ptr);

      // Protected CSR: RW flags illegal, RS with zero operand does not
      set_csr(12'h7C0, 32'h11, 1'b0);
      op_a[2] = 2'b01; addr_a[2] = 12'h7C0; wd_a[2] = 32'd5;
      thr_req = 4'b0100;
      expect_access("prot_rw", -1, 2, 32'h11, 1'b1, 0, '0, '0, 3);
      thr_req = '0; ref_ptr = ref_next_ptr(2, ref_ptr);
      @(negedge clk);
      op_a[2] = 2'b10; wd_a[2] = 32'd0;
      thr_req = 4'b0100;
      expect_access("prot_rs0", -1, 2, 32'h11, 1'b0, 0, '0, '0, 3);
      thr_req = '0; ref_ptr = ref_next_ptr(2, ref_ptr);

      // CSRRC
      set_csr(12'h305, 32'hFFFF_FFFF, 1'b1);
      op_a[3] = 2'b11; addr_a[3] = 12'h305; wd_a[3] = 32'hF0;
      thr_req = 4'b1000;
      expect_access("csrrc", -1, 3, 32'hFFFF_FFFF, 1'b0, 1, 12'h305, 32'hFFFF_FF0F, 3);
      thr_req = '0; ref_ptr = ref_next_ptr(3, ref_ptr);

      // Contention from reset with all requests held
      @(negedge clk);
      rst = 1'b1; ref_ptr = 0;
      for (int t = 0; t < N; t++) begin op_a[t] = 2'b00; addr_a[t] = 12'h340; end
      thr_req = 4'b1111;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         k = ref_pick(4'b1111, ref_ptr);
         expect_access($sformatf("contend%0d", i), -1, k, 32'hDEAD_BEEF, 1'b0, 0, '0, '0,
                       (i == 0) ? 3 : 4);
         ref_ptr = ref_next_ptr(k, ref_ptr);
      end
      thr_req = '0;

      // Reset in RD / WB / RESP aborts and restores thread 0 priority
      for (int ph = 1; ph <= 3; ph++) begin
         @(negedge clk);
         thr_req = 4'b0100;
         repeat (ph) @(negedge clk);
         rst = 1'b1; thr_req = '0;
         @(negedge clk);
         chk($sformatf("rst%0d_busy", ph),  64'(busy), 64'd0);
         chk($sformatf("rst%0d_csren", ph), 64'(csr_en), 64'd0);
         chk($sformatf("rst%0d_wr", ph),    64'(csr_wr), 64'd0);
         chk($sformatf("rst%0d_done", ph),  64'(thr_done), 64'd0);
         chk($sformatf("rst%0d_rdata", ph), 64'(thr_rdata), 64'd0);
         rst = 1'b0; ref_ptr = 0;
         thr_req = 4'b1001;
         k = ref_pick(4'b1001, ref_ptr);
         expect_access($sformatf("rst%0d_first", ph), -1, k, 32'hDEAD_BEEF, 1'b0, 0, '0, '0, 3);
         ref_ptr = ref_next_ptr(k, ref_ptr);
         thr_req = 4'b1000;
         expect_access($sformatf("rst%0d_second", ph), -1, 3, 32'hDEAD_BEEF, 1'b0, 0, '0, '0, 4);
         ref_ptr = ref_next_ptr(3, ref_ptr);
         thr_req = '0;
      end

      // Randomized rounds over eight CSRs at 0x100..0x107
      for (int i = 0; i < 8; i++) begin
         ref_mem[i]  = $urandom;
         ref_prot[i] = ($urandom_range(0, 3) != 0);
         set_csr(AW'(12'h100 + i), ref_mem[i], ref_prot[i]);
      end
      for (int r = 0; r < 40; r++) begin
         @(negedge clk);
         chk("idle_rdata",   64'(thr_rdata), 64'd0);
         chk("idle_illegal", 64'(thr_illegal), 64'd0);
         chk("idle_busy",    64'(busy), 64'd0);
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int t = 0; t < N; t++) begin
            op_a[t]   = 2'($urandom);
            ra[t]     = $urandom_range(0, 7);
            addr_a[t] = AW'(12'h100 + ra[t]);
            wd_a[t]   = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
         end
         thr_req = mask; pending = mask; first = 1;
         while (pending != '0) begin
            k    = ref_pick(pending, ref_ptr);
            old  = ref_mem[ra[k]];
            need = (op_a[k] == 2'b01) || ((op_a[k] == 2'b10 || op_a[k] == 2'b11) && wd_a[k] != '0);
            ill  = need && !ref_prot[ra[k]];
            case (op_a[k])
               2'b01:   nw = wd_a[k];
               2'b10:   nw = old | wd_a[k];
               default: nw = old & ~wd_a[k];
            endcase
            if (need && !ill) ref_mem[ra[k]] = nw;
            scr = ($urandom_range(0, 1) == 1) ? k : -1;
            expect_access($sformatf("rnd%0d_t%0d", r, k), scr, k, old, ill,
                          (need && !ill) ? 1 : 0, addr_a[k], nw, first ? 3 : 4);
            pending[k] = 1'b0;
            thr_req = pending;
            first = 0;
            ref_ptr = ref_next_ptr(k, ref_ptr);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
